// File: rtl/uart_hex_pkg.sv
// Shared types, ASCII constants and nibble conversion for the hex UART transmit path.
package uart_hex_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // Index of the character currently on the line within one transfer
    typedef logic [1:0] char_idx_t;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A_OFS = 8'h37;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    function automatic logic [7:0] nibble2ascii(input logic [3:0] n);
        return (n <= 4'd9) ? (ASCII_0 + {4'h0, n}) : (ASCII_A_OFS + {4'h0, n});
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// Single-byte 8N1 serialiser. iStart is honoured in IDLE or in the final stop-bit
// cycle (oDone), which lets the caller chain characters with no idle gap.
module uart_tx_core
    import uart_hex_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iStart,
    input  logic [7:0] iByte,
    output logic       oDone,
    output logic       oTx
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // tx_d is the level of the next cycle, so the line itself is a flop
    always_comb begin
        state_d = state_q;
        baud_d  = bit_end ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                tx_d   = 1'b1;
                if (iStart) begin
                    state_d = START;
                    shift_d = iByte;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (iStart) begin
                        state_d = START;
                        shift_d = iByte;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_comb begin
        oTx   = tx_q;
        oDone = (state_q == STOP) && bit_end;
    end

endmodule

// File: rtl/hex2ascii_uart_tx.sv
// Byte-to-hex-ASCII UART transmitter: handshake and character sequencer around uart_tx_core.
// Define HEX_TX_CRLF_EN to append CR LF after the two hex digits.
module hex2ascii_uart_tx
    import uart_hex_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [7:0] iData,
    input  logic       iValid,
    output logic       oReady,
    output logic       oBusy,
    output logic       oTx
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;

    if (CLKS_PER_BIT < 2) begin : g_rate_check
        $error("hex2ascii_uart_tx: CLK_FREQ/BAUD must be >= 2");
    end

`ifdef HEX_TX_CRLF_EN
    localparam char_idx_t LAST_IDX = char_idx_t'(3);
`else
    localparam char_idx_t LAST_IDX = char_idx_t'(1);
`endif

    function automatic logic [7:0] char_at(input logic [7:0] b, input char_idx_t idx);
        logic [7:0] c;
        case (idx)
            char_idx_t'(0): c = nibble2ascii(b[7:4]);
`ifdef HEX_TX_CRLF_EN
            char_idx_t'(2): c = ASCII_CR;
            char_idx_t'(3): c = ASCII_LF;
`endif
            default:        c = nibble2ascii(b[3:0]);
        endcase
        return c;
    endfunction

    logic [7:0] byte_q, byte_d;
    char_idx_t  idx_q, idx_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    logic       accept;
    logic       core_start, core_done;
    logic [7:0] core_byte;

    assign accept = iValid && ready_q;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            byte_q  <= '0;
            idx_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            byte_q  <= byte_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // The first character is taken straight from iData so its start bit begins the cycle after acceptance
    always_comb begin
        byte_d     = byte_q;
        idx_d      = idx_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        core_start = 1'b0;
        core_byte  = '0;
        if (accept) begin
            byte_d     = iData;
            idx_d      = '0;
            ready_d    = 1'b0;
            busy_d     = 1'b1;
            core_start = 1'b1;
            core_byte  = nibble2ascii(iData[7:4]);
        end else if (core_done) begin
            if (idx_q == LAST_IDX) begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end else begin
                idx_d      = char_idx_t'(idx_q + 1'b1);
                core_start = 1'b1;
                core_byte  = char_at(byte_q, char_idx_t'(idx_q + 1'b1));
            end
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .iClk  (iClk),
        .iRst  (iRst),
        .iStart(core_start),
        .iByte (core_byte),
        .oDone (core_done),
        .oTx   (oTx)
    );

    always_comb begin
        oReady = ready_q;
        oBusy  = busy_q;
    end

endmodule

// File: tb/tb_hex2ascii_uart_tx.sv
// Randomised self-checking bench for hex2ascii_uart_tx; line waveform compared against a per-cycle model.
module tb_hex2ascii_uart_tx;

    localparam int unsigned CPB = 10;
`ifdef HEX_TX_CRLF_EN
    localparam int unsigned NCH = 4;
`else
    localparam int unsigned NCH = 2;
`endif
    localparam int unsigned FCYC = 10 * CPB;
    localparam int unsigned NCYC = NCH * FCYC;

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic       iValid = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       oReady, oBusy, oTx;

    int unsigned checks = 0;
    int unsigned errors = 0;

    hex2ascii_uart_tx #(
        .CLK_FREQ(1000),
        .BAUD    (100)
    ) dut (
        .iClk  (iClk),
        .iRst  (iRst),
        .iData (iData),
        .iValid(iValid),
        .oReady(oReady),
        .oBusy (oBusy),
        .oTx   (oTx)
    );

    always #5 iClk = ~iClk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Character i of the transfer for byte b
    function automatic logic [7:0] exp_char(input logic [7:0] b, input int unsigned i);
        string hexdig;
        hexdig = "0123456789ABCDEF";
        case (i)
            0:       return hexdig[int'(b[7:4])];
            1:       return hexdig[int'(b[3:0])];
            2:       return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    // Per-cycle line level for one 8N1 frame, bit t of the result = cycle t of the frame
    function automatic logic [127:0] exp_frame(input logic [7:0] c);
        logic [127:0] f;
        logic [9:0]   bits;
        f = '0;
        bits = {1'b1, c, 1'b0};
        for (int k = 0; k < 10; k++)
            for (int j = 0; j < int'(CPB); j++)
                f[k * CPB + j] = bits[k];
        return f;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!oReady && n < 1000) begin
            @(negedge iClk);
            n++;
        end
        check_eq("ready_wait", 128'(oReady), 128'(1));
    endtask

    task automatic idle_line(input string tag, input int unsigned ncyc);
        int unsigned bad = 0;
        for (int unsigned t = 0; t < ncyc; t++) begin
            if (!oTx || oBusy || !oReady) bad++;
            @(negedge iClk);
        end
        check_eq(tag, 128'(bad), 128'(0));
    endtask

    // Presents b at a negedge with oReady high, captures the whole transfer and checks it
    task automatic xfer(input logic [7:0] b, input bit stream);
        logic [127:0] fr [NCH];
        int unsigned  busy_n;
        wait_ready();
        iData  = b;
        iValid = 1'b1;
        @(negedge iClk);
        busy_n = 0;
        for (int i = 0; i < int'(NCH); i++) fr[i] = '0;
        for (int unsigned t = 0; t < NCYC; t++) begin
            fr[t / FCYC][t % FCYC] = oTx;
            if (oBusy && !oReady) busy_n++;
            if (stream) iData = 8'($urandom);
            else        iValid = 1'b0;
            @(negedge iClk);
        end
        for (int i = 0; i < int'(NCH); i++)
            check_eq($sformatf("frame%0d_byte%02h", i, b), fr[i], exp_frame(exp_char(b, i)));
        check_eq($sformatf("busy_len_%02h", b), 128'(busy_n), 128'(NCYC));
        check_eq($sformatf("ready_back_%02h", b), {125'(0), oReady, oBusy, oTx}, 128'(3'b101));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge iClk);
        iRst = 1'b0;
        @(negedge iClk);
        check_eq("reset_out", {125'(0), oReady, oBusy, oTx}, 128'(3'b101));
        idle_line("idle_100", 100);

        xfer(8'h3A, 1'b0);
        xfer(8'h00, 1'b0);
        xfer(8'hFF, 1'b0);
        xfer(8'h09, 1'b0);
        xfer(8'hA0, 1'b0);

        // Continuous iValid with iData churning while busy
        for (int i = 0; i < 4; i++) xfer(8'($urandom), 1'b1);
        iValid = 1'b0;
        idle_line("idle_after_stream", 5);

        // Reset during d4 of the first character
        wait_ready();
        iData  = 8'hC3;
        iValid = 1'b1;
        @(negedge iClk);
        iValid = 1'b0;
        repeat (55) @(negedge iClk);
        iRst = 1'b1;
        @(negedge iClk);
        iRst = 1'b0;
        check_eq("abort_out", {125'(0), oReady, oBusy, oTx}, 128'(3'b101));
        idle_line("abort_idle", 50);
        xfer(8'h5C, 1'b0);

        for (int i = 0; i < 6; i++) xfer(8'($urandom), 1'($urandom_range(0, 1)));
        iValid = 1'b0;

`ifdef HEX_TX_CRLF_EN
        xfer(8'h7E, 1'b0);
`endif
        repeat (5) @(negedge iClk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
